// File: rtl/mix_seq_pkg.sv
// mix_seq_pkg: shared widths, mode-to-gain table and FSM state type for mix_sequencer
package mix_seq_pkg;

    localparam int MODE_W = 2;
    localparam int GAIN_W = 2;

    // Gain codes per mode, entry m at bits [m*GAIN_W +: GAIN_W]: m3..m0
    localparam logic [4*GAIN_W-1:0] SW0_TBL = {2'b10, 2'b01, 2'b00, 2'b01};
    localparam logic [4*GAIN_W-1:0] SW1_TBL = {2'b01, 2'b01, 2'b01, 2'b00};

    typedef enum logic {SETTLE, RUN} state_e;

    function automatic logic [GAIN_W-1:0] sw0_of(input logic [MODE_W-1:0] m);
        return SW0_TBL[int'(m)*GAIN_W +: GAIN_W];
    endfunction

    function automatic logic [GAIN_W-1:0] sw1_of(input logic [MODE_W-1:0] m);
        return SW1_TBL[int'(m)*GAIN_W +: GAIN_W];
    endfunction

endpackage

// File: rtl/mix_sequencer_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-level debouncer and 1-cycle rising-edge pulse
module btn_debounce #(
    parameter int DEB_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    localparam int CW = ($clog2(DEB_CYC) > 0) ? $clog2(DEB_CYC) : 1;

    logic          s1_q;
    logic          s2_q;
    logic          deb_q;
    logic          pulse_q;
    logic [CW-1:0] cnt_q;

    // Synchronize, then accept a new level only after DEB_CYC consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            deb_q   <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            pulse_q <= 1'b0;
            if (s2_q == deb_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(DEB_CYC - 1)) begin
                deb_q   <= s2_q;
                pulse_q <= s2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/mix_sequencer.sv
// mix_sequencer: mode/gain sequencer for signal_sum with settle blanking and sample pacing.
// Optional MIX_SEQ_PREV_BTN_EN adds a btn_prev input that steps the mode backwards.
module mix_sequencer
    import mix_seq_pkg::*;
#(
    parameter int DEB_CYC    = 4,
    parameter int DWELL_CYC  = 16,
    parameter int SETTLE_CYC = 3,
    parameter int SAMPLE_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_next,
`ifdef MIX_SEQ_PREV_BTN_EN
    input  logic              btn_prev,
`endif
    input  logic              auto_en,
    input  logic              sample_ready,
    output logic [GAIN_W-1:0] sw0,
    output logic [GAIN_W-1:0] sw1,
    output logic [MODE_W-1:0] mode,
    output logic              settling,
    output logic              sample_valid
);

    localparam int DW = ($clog2(DWELL_CYC) > 0) ? $clog2(DWELL_CYC) : 1;
    localparam int SW = ($clog2(SETTLE_CYC) > 0) ? $clog2(SETTLE_CYC) : 1;
    localparam int VW = ($clog2(SAMPLE_DIV) > 0) ? $clog2(SAMPLE_DIV) : 1;

    state_e            state_q;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;
    logic [GAIN_W-1:0] sw0_q;
    logic [GAIN_W-1:0] sw1_q;
    logic [SW-1:0]     settle_q;
    logic [DW-1:0]     dwell_q;
    logic [VW-1:0]     div_q;
    logic              valid_q;
    logic              settling_q;
    logic              next_req;
    logic              prev_req;
    logic              dwell_exp;
    logic              trig;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_next),
        .pulse_o(next_req)
    );

`ifdef MIX_SEQ_PREV_BTN_EN
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_prev (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_prev),
        .pulse_o(prev_req)
    );
`else
    assign prev_req = 1'b0;
`endif

    // Change trigger: one button edge (opposing edges cancel) or dwell expiry, RUN only
    always_comb begin
        dwell_exp = auto_en && (dwell_q == DW'(DWELL_CYC - 1));
        trig      = (state_q == RUN) && ((next_req ^ prev_req) || dwell_exp);
        mode_d    = (prev_req && !next_req) ? mode_q - 1'b1 : mode_q + 1'b1;
    end

    // Mode FSM with settle blanking, dwell timer and sample handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SETTLE;
            mode_q     <= '0;
            sw0_q      <= sw0_of('0);
            sw1_q      <= sw1_of('0);
            settle_q   <= '0;
            dwell_q    <= '0;
            div_q      <= '0;
            valid_q    <= 1'b0;
            settling_q <= 1'b1;
        end else if (state_q == SETTLE) begin
            valid_q <= 1'b0;
            if (settle_q == SW'(SETTLE_CYC - 1)) begin
                state_q    <= RUN;
                settling_q <= 1'b0;
                settle_q   <= '0;
            end else begin
                settle_q <= settle_q + 1'b1;
            end
        end else if (trig) begin
            mode_q     <= mode_d;
            sw0_q      <= sw0_of(mode_d);
            sw1_q      <= sw1_of(mode_d);
            state_q    <= SETTLE;
            settling_q <= 1'b1;
            settle_q   <= '0;
            dwell_q    <= '0;
            div_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            dwell_q <= auto_en ? dwell_q + 1'b1 : '0;
            if (valid_q) begin
                if (sample_ready) valid_q <= 1'b0;
            end else if (div_q == VW'(SAMPLE_DIV - 1)) begin
                valid_q <= 1'b1;
                div_q   <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    assign sw0          = sw0_q;
    assign sw1          = sw1_q;
    assign mode         = mode_q;
    assign settling     = settling_q;
    assign sample_valid = valid_q;

endmodule

// File: tb/tb_mix_sequencer.sv
// tb_mix_sequencer: directed bench with a mode-change scoreboard for mix_sequencer
module tb_mix_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_next = 1'b0;
    logic       auto_en = 1'b0;
    logic       sample_ready = 1'b0;
    logic [1:0] sw0;
    logic [1:0] sw1;
    logic [1:0] mode;
    logic       settling;
    logic       sample_valid;
`ifdef MIX_SEQ_PREV_BTN_EN
    logic       btn_prev = 1'b0;
`endif

    typedef struct packed {
        logic [1:0] m;
        logic [1:0] s0;
        logic [1:0] s1;
    } obs_t;

    obs_t       exp_q[$];
    obs_t       seen_q[$];
    logic [1:0] last_mode = 2'd0;
    logic [1:0] t0[4] = '{2'b01, 2'b00, 2'b01, 2'b10};
    logic [1:0] t1[4] = '{2'b00, 2'b01, 2'b01, 2'b01};
    int         n_cmp = 0;
    int         n_bad = 0;

    mix_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_next    (btn_next),
`ifdef MIX_SEQ_PREV_BTN_EN
        .btn_prev    (btn_prev),
`endif
        .auto_en     (auto_en),
        .sample_ready(sample_ready),
        .sw0         (sw0),
        .sw1         (sw1),
        .mode        (mode),
        .settling    (settling),
        .sample_valid(sample_valid)
    );

    always #5 clk = ~clk;

    // Record every mode change seen outside reset
    always @(negedge clk) begin
        if (rst_n && mode !== last_mode) seen_q.push_back({mode, sw0, sw1});
        last_mode = mode;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] m);
        exp_q.push_back({m, t0[m], t1[m]});
    endtask

    task automatic drain(input string tag);
        obs_t o;
        obs_t e;
        chk8({tag, "_count"}, 8'(seen_q.size()), 8'(exp_q.size()));
        while (seen_q.size() > 0 && exp_q.size() > 0) begin
            o = seen_q.pop_front();
            e = exp_q.pop_front();
            chk8(tag, 8'(o), 8'(e));
        end
        seen_q.delete();
        exp_q.delete();
    endtask

    initial begin
        tick(2);
        chk2("rst_mode", mode, 2'd0);
        chk2("rst_sw0", sw0, 2'b01);
        chk2("rst_sw1", sw1, 2'b00);
        chk1("rst_settling", settling, 1'b1);
        chk1("rst_valid", sample_valid, 1'b0);
        rst_n = 1'b1;
        tick(2);
        chk1("settle_hold", settling, 1'b1);
        tick(1);
        chk1("settle_done", settling, 1'b0);

        tick(3);
        chk1("valid_early", sample_valid, 1'b0);
        tick(1);
        chk1("valid_rise", sample_valid, 1'b1);
        tick(5);
        chk1("valid_hold", sample_valid, 1'b1);
        sample_ready = 1'b1;
        tick(1);
        chk1("valid_accept_drop", sample_valid, 1'b0);
        sample_ready = 1'b0;
        tick(3);
        chk1("valid_restart", sample_valid, 1'b0);
        tick(1);
        chk1("valid_reassert", sample_valid, 1'b1);

        btn_next = 1'b1;
        tick(2);
        btn_next = 1'b0;
        tick(10);
        chk2("glitch_mode", mode, 2'd0);
        drain("glitch");

        push(2'd1);
        btn_next = 1'b1;
        tick(6);
        chk2("hold_edge6", mode, 2'd0);
        tick(1);
        chk2("hold_edge7", mode, 2'd1);
        chk2("hold_sw0", sw0, 2'b00);
        chk2("hold_sw1", sw1, 2'b01);
        chk1("hold_settling", settling, 1'b1);
        chk1("trig_clears_valid", sample_valid, 1'b0);
        tick(2);
        chk1("hold_settle3", settling, 1'b1);
        tick(1);
        chk1("hold_run", settling, 1'b0);
        btn_next = 1'b0;
        drain("hold");

        tick(6);
        auto_en = 1'b1;
        push(2'd2);
        tick(10);
        btn_next = 1'b1;
        tick(6);
        chk2("auto_first", mode, 2'd2);
        chk1("auto_settling", settling, 1'b1);
        tick(3);
        chk1("drop_run", settling, 1'b0);
        chk2("drop_mode", mode, 2'd2);
        btn_next = 1'b0;
        drain("drop");

        push(2'd3);
        tick(9);
        btn_next = 1'b1;
        tick(6);
        chk2("coincide_before", mode, 2'd2);
        tick(1);
        chk2("coincide_mode", mode, 2'd3);
        btn_next = 1'b0;
        auto_en = 1'b0;
        tick(30);
        chk2("coincide_single", mode, 2'd3);
        drain("coincide");

        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] m;
            m = 2'(i);
            push(m);
            tick(i == 0 ? 15 : 18);
            chk2("auto_wait", mode, m - 2'd1);
            tick(1);
            chk2("auto_step", mode, m);
        end
        auto_en = 1'b0;
        tick(40);
        chk2("auto_freeze", mode, 2'd0);
        drain("auto");

        auto_en = 1'b1;
        push(2'd1);
        push(2'd2);
        tick(16);
        chk2("pre_reset_m1", mode, 2'd1);
        tick(19);
        chk2("pre_reset_m2", mode, 2'd2);
        auto_en = 1'b0;
        tick(7);
        chk1("pre_reset_valid", sample_valid, 1'b1);
        drain("pre_reset");
        rst_n = 1'b0;
        #1;
        chk2("mid_rst_mode", mode, 2'd0);
        chk2("mid_rst_sw0", sw0, 2'b01);
        chk2("mid_rst_sw1", sw1, 2'b00);
        chk1("mid_rst_settling", settling, 1'b1);
        chk1("mid_rst_valid", sample_valid, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk1("post_rst_settle", settling, 1'b1);
        tick(1);
        chk1("post_rst_run", settling, 1'b0);

`ifdef MIX_SEQ_PREV_BTN_EN
        push(2'd3);
        btn_prev = 1'b1;
        tick(7);
        chk2("prev_mode", mode, 2'd3);
        chk2("prev_sw0", sw0, 2'b10);
        chk2("prev_sw1", sw1, 2'b01);
        btn_prev = 1'b0;
        tick(10);
        btn_next = 1'b1;
        btn_prev = 1'b1;
        tick(7);
        chk2("both_mode", mode, 2'd3);
        chk1("both_settling", settling, 1'b0);
        tick(3);
        chk1("both_settling_late", settling, 1'b0);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        tick(10);
`endif

        tick(2);
        drain("final");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
